clape_poly: RTL and testbench

//  Parametrised, polyphonic successor of the single-note piano key renderer.

---
 rtl/clape_poly_pkg.sv | 50 +++++
 rtl/clape_poly_if.sv | 20 ++
 rtl/clape_poly_tracker.sv | 89 ++++++++
 rtl/clape_poly.sv | 99 +++++++++
 tb/tb_clape_poly.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/clape_poly_pkg.sv
// Shared definitions for the polyphonic key renderer: PS/2 scan codes,
// key table lookup, decoder state encoding and default colours.
package clape_pkg;

    localparam logic [7:0]  SC_BREAK     = 8'hF0;
    localparam logic [7:0]  SC_EXT       = 8'hE0;
    localparam int          MAX_KEYS     = 16;
    localparam logic [11:0] DEF_LIT_RGB  = 12'h0F0;
    localparam logic [11:0] DEF_IDLE_RGB = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } dec_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } key_hit_t;

    // Key 0 answers to two codes (1C and 0E); the rest have one each.
    function automatic key_hit_t key_lookup(input logic [7:0] code);
        key_hit_t h;
        h.valid = 1'b1;
        h.idx   = 4'd0;
        case (code)
            8'h1C, 8'h0E: h.idx = 4'd0;
            8'h1B:        h.idx = 4'd1;
            8'h23:        h.idx = 4'd2;
            8'h2B:        h.idx = 4'd3;
            8'h34:        h.idx = 4'd4;
            8'h33:        h.idx = 4'd5;
            8'h3B:        h.idx = 4'd6;
            8'h42:        h.idx = 4'd7;
            8'h4B:        h.idx = 4'd8;
            8'h4C:        h.idx = 4'd9;
            8'h52:        h.idx = 4'd10;
            8'h54:        h.idx = 4'd11;
            8'h5B:        h.idx = 4'd12;
            8'h5D:        h.idx = 4'd13;
            8'h15:        h.idx = 4'd14;
            8'h1D:        h.idx = 4'd15;
            default:      h.valid = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/clape_poly_if.sv
// PS/2 frame input and VGA pixel bus between sync/receiver logic and the renderer.
interface clape_poly_if;
    logic        data_valid;
    logic [10:0] sda_to_do;
    logic        disp_en;
    logic [10:0] count_hsync;
    logic [9:0]  count_vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    modport master (
        output data_valid, sda_to_do, disp_en, count_hsync, count_vsync,
        input  red, green, blue
    );
    modport slave (
        input  data_valid, sda_to_do, disp_en, count_hsync, count_vsync,
        output red, green, blue
    );
endinterface

// File: rtl/clape_poly_tracker.sv
// PS/2 make/break decoder with held-key vector and per-key sustain counters.
module ps2_key_tracker
    import clape_pkg::*;
#(
    parameter int N_KEYS        = 8,
    parameter int TICK_DIV      = 2500000,
    parameter int SUSTAIN_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [7:0]        scan,
    output logic [N_KEYS-1:0] held_keys,
    output logic [N_KEYS-1:0] sus_on
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SUSTAIN_TICKS > 0) ? $clog2(SUSTAIN_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SUS_LOAD  = SW'(SUSTAIN_TICKS);

    dec_state_t        state, state_nxt;
    logic [TW-1:0]     tcnt;
    logic              tick;
    key_hit_t          hit;
    logic [N_KEYS-1:0] key_oh, make, brk;
    logic [SW-1:0]     sus [N_KEYS];

    assign hit  = key_lookup(scan);
    assign tick = (tcnt == TICK_LAST);

    // Codes mapping beyond N_KEYS fall out here and are ignored.
    always_comb begin
        key_oh = '0;
        for (int i = 0; i < N_KEYS; i++)
            if (hit.valid && hit.idx == 4'(i)) key_oh[i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;

    always_comb begin
        state_nxt = state;
        make      = '0;
        brk       = '0;
        if (data_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan == SC_BREAK)    state_nxt = ST_BREAK;
                    else if (scan == SC_EXT) state_nxt = ST_EXT;
                    else                     make      = key_oh;
                end
                ST_BREAK: begin
                    brk       = key_oh;
                    state_nxt = ST_IDLE;
                end
                ST_EXT:       state_nxt = (scan == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                ST_EXT_BREAK: state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) tcnt <= '0;
        else      tcnt <= tick ? '0 : tcnt + 1'b1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) held_keys <= '0;
        else      held_keys <= (held_keys | make) & ~brk;

    // Break load takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_KEYS; i++) sus[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (make[i])                                  sus[i] <= '0;
                else if (brk[i])                              sus[i] <= SUS_LOAD;
                else if (tick && !held_keys[i] && sus[i] != '0) sus[i] <= sus[i] - 1'b1;
            end
        end
    end

    always_comb
        for (int i = 0; i < N_KEYS; i++) sus_on[i] = (sus[i] != '0);

endmodule

// File: rtl/clape_poly.sv
// Polyphonic piano key renderer: key tracking plus coloured VGA bars with a
// divider-free column tracker and a registered pixel output.
module clape_poly
    import clape_pkg::*;
#(
    parameter int          N_KEYS        = 8,
    parameter int          KEY_W         = 100,
    parameter int          GAP_W         = 2,
    parameter int          KEY_H         = 600,
    parameter int          TICK_DIV      = 2500000,
    parameter int          SUSTAIN_TICKS = 4,
    parameter logic [11:0] LIT_RGB       = DEF_LIT_RGB,
    parameter logic [11:0] IDLE_RGB      = DEF_IDLE_RGB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] switch_uri,
    clape_poly_if.slave       bus,
    output logic [N_KEYS-1:0] held_keys
);

    localparam int KW = $clog2(N_KEYS + 1);
    localparam int OW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [OW-1:0] OFF_LAST  = OW'(KEY_W - 1);
    localparam logic [OW-1:0] GAP_START = OW'(KEY_W - GAP_W);
    localparam logic [KW-1:0] K_MAX     = KW'(N_KEYS);

    logic [N_KEYS-1:0] sus_on, lit;
    logic [10:0]       hs_q;
    logic [KW-1:0]     k_q, k_cur;
    logic [OW-1:0]     off_q, off_cur;
    logic              lit_k, black;
    logic [11:0]       rgb;

    ps2_key_tracker #(
        .N_KEYS        (N_KEYS),
        .TICK_DIV      (TICK_DIV),
        .SUSTAIN_TICKS (SUSTAIN_TICKS)
    ) u_trk (
        .clk        (clk),
        .rst        (rst),
        .data_valid (bus.data_valid),
        .scan       (bus.sda_to_do[8:1]),
        .held_keys  (held_keys),
        .sus_on     (sus_on)
    );

    assign lit = held_keys | sus_on | switch_uri;

    // Column 0 always resynchronises; a held column keeps its position, any
    // other change is taken as a one-pixel step.
    always_comb begin
        k_cur   = k_q;
        off_cur = off_q;
        if (bus.count_hsync == 11'd0) begin
            k_cur   = '0;
            off_cur = '0;
        end else if (bus.count_hsync != hs_q) begin
            if (off_q == OFF_LAST) begin
                off_cur = '0;
                if (k_q != K_MAX) k_cur = k_q + 1'b1;
            end else begin
                off_cur = off_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hs_q  <= '0;
            k_q   <= '0;
            off_q <= '0;
        end else begin
            hs_q  <= bus.count_hsync;
            k_q   <= k_cur;
            off_q <= off_cur;
        end

    always_comb begin
        lit_k = 1'b0;
        for (int i = 0; i < N_KEYS; i++)
            if (k_cur == KW'(i)) lit_k = lit[i];
    end

    assign black = bus.disp_en
                || (int'(bus.count_vsync) >= KEY_H)
                || (int'(bus.count_hsync) >= N_KEYS * KEY_W)
                || (off_cur >= GAP_START);

    always_ff @(posedge clk or negedge rst)
        if (!rst)       rgb <= '0;
        else if (black) rgb <= '0;
        else            rgb <= lit_k ? LIT_RGB : IDLE_RGB;

    assign bus.red   = rgb[11:8];
    assign bus.green = rgb[7:4];
    assign bus.blue  = rgb[3:0];

endmodule

// File: tb/tb_clape_poly.sv
// Directed bench for clape_poly: two instances (8x100 and 12x64) share one
// stimulus stream; each checks its own held keys and pixel colour.
module tb_clape_poly;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic [10:0] sda = '0;
    logic        den = 1'b0;
    logic [10:0] hs  = '0;
    logic [9:0]  vs  = '0;
    logic [7:0]  sw0 = '0;
    logic [11:0] sw1 = '0;
    logic [7:0]  held0;
    logic [11:0] held1;
    logic [11:0] rgb0, rgb1;
    int          n_chk = 0;
    int          n_fail = 0;
    int          tcnt_m;

    always #5 clk = ~clk;

    clape_poly_if if0();
    clape_poly_if if1();
    assign if0.data_valid = dv;  assign if1.data_valid = dv;
    assign if0.sda_to_do  = sda; assign if1.sda_to_do  = sda;
    assign if0.disp_en    = den; assign if1.disp_en    = den;
    assign if0.count_hsync = hs; assign if1.count_hsync = hs;
    assign if0.count_vsync = vs; assign if1.count_vsync = vs;
    assign rgb0 = {if0.red, if0.green, if0.blue};
    assign rgb1 = {if1.red, if1.green, if1.blue};

    clape_poly #(.N_KEYS(8), .KEY_W(100), .GAP_W(2), .KEY_H(600),
                 .TICK_DIV(16), .SUSTAIN_TICKS(2)) u0 (
        .clk(clk), .rst(rst), .switch_uri(sw0), .bus(if0), .held_keys(held0));

    clape_poly #(.N_KEYS(12), .KEY_W(64), .GAP_W(2), .KEY_H(600),
                 .TICK_DIV(16), .SUSTAIN_TICKS(2)) u1 (
        .clk(clk), .rst(rst), .switch_uri(sw1), .bus(if1), .held_keys(held1));

    // Sustain tick phase: free-running 0..15 from reset release.
    always @(posedge clk or negedge rst)
        if (!rst) tcnt_m <= 0;
        else      tcnt_m <= (tcnt_m == 15) ? 0 : tcnt_m + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        sda = frame(b);
        dv  = 1'b1;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    // Walk the column counter up from 0 and hold it; ends with the pixel settled.
    task automatic goto(input int col, input int row, input logic de);
        vs  = 10'(row);
        den = de;
        for (int c = 0; c <= col; c++) begin
            hs = 11'(c);
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int green_cnt, exp_cnt, ticks;
        #2 rst = 1'b0;
        #1;
        check("rst_held0", held0, 8'h00);
        check("rst_held1", held1, 12'h000);
        check("rst_rgb0", rgb0, 12'h000);
        check("rst_rgb1", rgb1, 12'h000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single key, pixel colours
        send(8'h1C);
        check("make_1c_h0", held0, 8'h01);
        check("make_1c_h1", held1, 12'h001);
        goto(50, 10, 1'b0);
        check("c50_rgb0", rgb0, 12'h0F0);
        check("c50_rgb1", rgb1, 12'h0F0);
        goto(150, 10, 1'b0);
        check("c150_rgb0", rgb0, 12'hFFF);
        check("c150_rgb1", rgb1, 12'hFFF);
        send(8'h1C);
        check("repeat_make", held0, 8'h01);

        // polyphony and break
        send(8'h23);
        check("poly_h0", held0, 8'h05);
        send(8'hF0); send(8'h1C);
        check("brk_1c_h0", held0, 8'h04);
        check("brk_1c_h1", held1, 12'h004);

        // sustain length after break
        send(8'h1C);
        goto(50, 10, 1'b0);
        check("sus_pre", rgb0, 12'h0F0);
        send(8'hF0); send(8'h1C);
        check("sus_held", held0, 8'h04);
        green_cnt = 0; exp_cnt = 0; ticks = 0;
        for (int n = 0; n < 60; n++) begin
            if (ticks < 2) begin
                exp_cnt++;
                if (tcnt_m == 15) ticks++;
            end
            @(negedge clk);
            if (rgb0 == 12'h0F0) green_cnt++;
        end
        check("sus_len", green_cnt, exp_cnt);
        check("sus_end", rgb0, 12'hFFF);
        send(8'hF0); send(8'h23);
        check("brk_23", held0, 8'h00);

        // extended codes and unknown bytes
        send(8'h1C);
        send(8'hE0); send(8'h1C);
        check("ext_make", held0, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h1C);
        check("ext_brk", held0, 8'h01);
        send(8'h5A);
        check("unknown", held0, 8'h01);
        send(8'hF0); send(8'h1C);
        check("idle_again", held0, 8'h00);
        send(8'h0E);
        check("alt_code", held0, 8'h01);
        send(8'hF0); send(8'h0E);
        check("alt_brk", held0, 8'h00);
        send(8'h4B);
        check("k8_n8", held0, 8'h00);
        check("k8_n12", held1, 12'h100);
        send(8'hF0); send(8'h4B);

        // blanking and gaps
        goto(97, 10, 1'b0);
        check("c97_rgb0", rgb0, 12'hFFF);
        goto(98, 10, 1'b0);
        check("c98_rgb0", rgb0, 12'h000);
        check("c98_rgb1", rgb1, 12'hFFF);
        goto(99, 10, 1'b0);
        check("c99_rgb0", rgb0, 12'h000);
        goto(50, 600, 1'b0);
        check("row600_rgb0", rgb0, 12'h000);
        check("row600_rgb1", rgb1, 12'h000);
        goto(50, 599, 1'b0);
        check("row599_rgb0", rgb0, 12'hFFF);
        goto(61, 10, 1'b0);
        check("c61_rgb1", rgb1, 12'hFFF);
        goto(62, 10, 1'b0);
        check("c62_rgb1", rgb1, 12'h000);
        check("c62_rgb0", rgb0, 12'hFFF);
        goto(768, 10, 1'b0);
        check("c768_rgb0", rgb0, 12'hFFF);
        check("c768_rgb1", rgb1, 12'h000);
        goto(800, 10, 1'b0);
        check("c800_rgb0", rgb0, 12'h000);
        goto(50, 10, 1'b1);
        check("de_rgb0", rgb0, 12'h000);

        // one-clock pixel latency
        sw0 = 8'h01;
        goto(50, 10, 1'b0);
        check("sw_c50", rgb0, 12'h0F0);
        den = 1'b1;
        #1;
        check("lag_before", rgb0, 12'h0F0);
        @(negedge clk);
        check("lag_after", rgb0, 12'h000);
        den = 1'b0;
        sw0 = 8'h00;

        // async reset mid-frame
        send(8'h1C); send(8'h23); send(8'hF0); send(8'h23);
        goto(50, 10, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mrst_held0", held0, 8'h00);
        check("mrst_held1", held1, 12'h000);
        check("mrst_rgb0", rgb0, 12'h000);
        check("mrst_rgb1", rgb1, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        goto(50, 10, 1'b0);
        check("post_rst_c50", rgb0, 12'hFFF);
        sw0 = 8'h80;
        sw1 = 12'h800;
        goto(750, 10, 1'b0);
        check("sw_c750_rgb0", rgb0, 12'h0F0);
        check("sw_c750_rgb1", rgb1, 12'h0F0);
        sw1 = 12'h080;
        goto(480, 10, 1'b0);
        check("sw_c480_rgb1", rgb1, 12'h0F0);
        check("sw_c480_rgb0", rgb0, 12'hFFF);
        send(8'h4B);
        goto(520, 10, 1'b0);
        check("k8_c520_rgb1", rgb1, 12'h0F0);
        check("k8_c520_rgb0", rgb0, 12'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
